// File: rtl/keypad_scan_debounce_if.sv
// Keypad scanner port bundle: keypad pins (row drive, column sense) plus the
// decoded key stream handed to the display/decoder logic.
interface keypad_scan_debounce_if #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int DEPTH = 2,
    parameter int KW    = $clog2(ROWS * COLS)
);
    logic [COLS-1:0]     col;
    logic [ROWS-1:0]     row;
    logic [KW-1:0]       key_code;
    logic                key_valid;
    logic                pressed;
    logic [DEPTH*KW-1:0] digits;

    // Scanner side: drives the rows and publishes accepted keys.
    modport master (
        input  col,
        output row,
        output key_code,
        output key_valid,
        output pressed,
        output digits
    );

    // Keypad/consumer side: drives the columns and watches the key stream.
    modport slave (
        output col,
        input  row,
        input  key_code,
        input  key_valid,
        input  pressed,
        input  digits
    );
endinterface

// File: rtl/keypad_scan_debounce.sv
// Matrix-keypad scanner: rotates a one-hot row drive, locks onto the first key
// seen, debounces its press and release on scan ticks, and keeps a short
// history of accepted key codes for a multi-digit display.
module keypad_scan_debounce #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 8,
    parameter int DEPTH      = 2,
    parameter int RESET_CODE = 13
) (
    input  logic                   clk,
    input  logic                   reset,
    keypad_scan_debounce_if.master kp
);
    localparam int KW = $clog2(ROWS * COLS);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int NW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        HELD,
        REL_DB
    } state_t;

    logic [COLS-1:0] col_meta_reg;
    logic [COLS-1:0] col_sync_reg;
    logic [DW-1:0]   dwell_reg;
    logic [DW-1:0]   dwell_next;
    logic [RW-1:0]   row_idx_reg;
    logic [RW-1:0]   row_idx_next;
    logic [RW-1:0]   row_rot;
    logic [CW-1:0]   lcol_reg;
    logic [CW-1:0]   lcol_next;
    logic [CW-1:0]   prio_col;
    logic [CW-1:0]   code_col;
    logic [NW-1:0]   cnt_reg;
    logic [NW-1:0]   cnt_next;
    state_t          state_reg;
    state_t          state_next;
    logic            pressed_reg;
    logic            pressed_next;
    logic [KW-1:0]   key_code_reg;
    logic [KW-1:0]   digits_reg [DEPTH];
    logic [KW-1:0]   accept_code;
    logic            accept;
    logic            tick;
    logic            col_hit;
    logic [ROWS-1:0]     row_dec;
    logic [DEPTH*KW-1:0] digits_flat;

    // Two-flop synchroniser: the column pins are asynchronous to clk.
    always_ff @(posedge clk) begin
        if (!reset) begin
            col_meta_reg <= '0;
            col_sync_reg <= '0;
        end else begin
            col_meta_reg <= kp.col;
            col_sync_reg <= col_meta_reg;
        end
    end

    assign tick       = (dwell_reg == DW'(SCAN_DIV - 1));
    assign dwell_next = tick ? '0 : dwell_reg + 1'b1;
    assign row_rot    = (row_idx_reg == RW'(ROWS - 1)) ? '0 : row_idx_reg + 1'b1;
    assign col_hit    = col_sync_reg[lcol_reg];

    // Highest-numbered active column wins when several are high together.
    always_comb begin
        prio_col = '0;
        for (int c = 0; c < COLS; c++) begin
            if (col_sync_reg[c]) begin
                prio_col = CW'(c);
            end
        end
    end

    // Scan/debounce decisions; everything except the dwell counter moves only on a tick.
    always_comb begin
        state_next   = state_reg;
        row_idx_next = row_idx_reg;
        lcol_next    = lcol_reg;
        cnt_next     = cnt_reg;
        pressed_next = pressed_reg;
        accept       = 1'b0;
        code_col     = lcol_reg;
        if (tick) begin
            case (state_reg)
                SCAN: begin
                    if (col_sync_reg == '0) begin
                        row_idx_next = row_rot;
                    end else begin
                        lcol_next = prio_col;
                        code_col  = prio_col;
                        if (DEBOUNCE == 1) begin
                            accept       = 1'b1;
                            pressed_next = 1'b1;
                            cnt_next     = '0;
                            state_next   = HELD;
                        end else begin
                            cnt_next   = NW'(1);
                            state_next = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (col_hit) begin
                        if (cnt_reg == NW'(DEBOUNCE - 1)) begin
                            accept       = 1'b1;
                            pressed_next = 1'b1;
                            cnt_next     = '0;
                            state_next   = HELD;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end else begin
                        cnt_next     = '0;
                        row_idx_next = row_rot;
                        state_next   = SCAN;
                    end
                end
                HELD: begin
                    if (!col_hit) begin
                        if (DEBOUNCE == 1) begin
                            pressed_next = 1'b0;
                            cnt_next     = '0;
                            row_idx_next = row_rot;
                            state_next   = SCAN;
                        end else begin
                            cnt_next   = NW'(1);
                            state_next = REL_DB;
                        end
                    end
                end
                REL_DB: begin
                    if (!col_hit) begin
                        if (cnt_reg == NW'(DEBOUNCE - 1)) begin
                            pressed_next = 1'b0;
                            cnt_next     = '0;
                            row_idx_next = row_rot;
                            state_next   = SCAN;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end else begin
                        cnt_next   = '0;
                        state_next = HELD;
                    end
                end
                default: begin
                    cnt_next   = '0;
                    state_next = SCAN;
                end
            endcase
        end
        accept_code = KW'(int'(row_idx_reg) * COLS + int'(code_col));
    end

    // Scanner state registers; reset wins in every state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dwell_reg   <= '0;
            row_idx_reg <= '0;
            lcol_reg    <= '0;
            cnt_reg     <= '0;
            state_reg   <= SCAN;
            pressed_reg <= 1'b0;
        end else begin
            dwell_reg   <= dwell_next;
            row_idx_reg <= row_idx_next;
            lcol_reg    <= lcol_next;
            cnt_reg     <= cnt_next;
            state_reg   <= state_next;
            pressed_reg <= pressed_next;
        end
    end

    // Accepted key: latch its code and push it into the history, newest in slot 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_code_reg <= KW'(RESET_CODE);
            for (int i = 0; i < DEPTH; i++) begin
                digits_reg[i] <= KW'(RESET_CODE);
            end
        end else if (accept) begin
            key_code_reg  <= accept_code;
            digits_reg[0] <= accept_code;
            for (int i = DEPTH - 1; i > 0; i--) begin
                digits_reg[i] <= digits_reg[i-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            assign row_dec[gi] = (row_idx_reg == RW'(gi));
        end
        for (gi = 0; gi < DEPTH; gi++) begin : g_digit
            assign digits_flat[gi*KW +: KW] = digits_reg[gi];
        end
    endgenerate

    assign kp.row       = row_dec;
    assign kp.key_code  = key_code_reg;
    assign kp.key_valid = accept & reset;
    assign kp.pressed   = pressed_reg;
    assign kp.digits    = digits_flat;
endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: a physical keypad model feeds the columns
// from the driven row, a tick-level behavioural model predicts every output
// each cycle, and directed scenarios pin the model with literal values.
module tb_keypad_scan_debounce;
    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int SCAN_DIV   = 4;
    localparam int DEBOUNCE   = 3;
    localparam int DEPTH      = 2;
    localparam int RESET_CODE = 13;
    localparam int KW         = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [COLS-1:0] keys [ROWS];

    int n_cmp = 0;
    int n_err = 0;
    int kv_count = 0;

    always #5 clk = ~clk;

    keypad_scan_debounce_if #(.ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH)) kp ();

    keypad_scan_debounce #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE), .DEPTH(DEPTH), .RESET_CODE(RESET_CODE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .kp(kp)
    );

    // Keypad matrix: a closed switch connects its row line to its column line.
    always_comb begin
        kp.col = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (kp.row[r] === 1'b1) kp.col = kp.col | keys[r];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (tick level) ----------------
    bit              armed = 1'b0;
    int              m_row, m_cyc, m_lock, m_agree, m_rel, m_code;
    bit              m_held;
    logic [COLS-1:0] m_s1, m_s2;
    int              hist[$];

    function automatic int top_col(input logic [COLS-1:0] v);
        int r = 0;
        for (int c = 0; c < COLS; c++) if (v[c]) r = c;
        return r;
    endfunction

    function bit m_accepts();
        if (m_cyc != SCAN_DIV - 1) return 1'b0;
        if (m_lock < 0) return (m_s2 != 0) && (DEBOUNCE == 1);
        return !m_held && m_s2[m_lock] && (m_agree + 1 >= DEBOUNCE);
    endfunction

    task m_take();
        m_held = 1'b1;
        m_rel  = 0;
        m_code = m_row * COLS + m_lock;
        hist.push_front(m_code);
        void'(hist.pop_back());
    endtask

    always @(posedge clk) begin : model
        logic [COLS-1:0] pins;
        if (!reset) begin
            m_row = 0; m_cyc = 0; m_lock = -1; m_agree = 0; m_rel = 0;
            m_held = 1'b0; m_s1 = '0; m_s2 = '0; m_code = RESET_CODE;
            hist = {};
            for (int i = 0; i < DEPTH; i++) hist.push_back(RESET_CODE);
            armed = 1'b1;
        end else if (armed) begin
            pins = keys[m_row];
            if (m_cyc == SCAN_DIV - 1) begin
                if (m_lock < 0) begin
                    if (m_s2 != 0) begin
                        m_lock  = top_col(m_s2);
                        m_agree = 1;
                        if (m_agree >= DEBOUNCE) m_take();
                    end else begin
                        m_row = (m_row + 1) % ROWS;
                    end
                end else if (!m_held) begin
                    if (m_s2[m_lock]) begin
                        m_agree++;
                        if (m_agree >= DEBOUNCE) m_take();
                    end else begin
                        m_lock = -1; m_agree = 0;
                        m_row = (m_row + 1) % ROWS;
                    end
                end else begin
                    if (!m_s2[m_lock]) begin
                        m_rel++;
                        if (m_rel >= DEBOUNCE) begin
                            m_held = 1'b0; m_lock = -1; m_rel = 0; m_agree = 0;
                            m_row = (m_row + 1) % ROWS;
                        end
                    end else begin
                        m_rel = 0;
                    end
                end
            end
            m_s2  = m_s1;
            m_s1  = pins;
            m_cyc = (m_cyc + 1) % SCAN_DIV;
        end
    end

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin : compare
        logic [DEPTH*KW-1:0] d;
        if (armed) begin
            d = '0;
            for (int i = 0; i < DEPTH; i++) d[i*KW +: KW] = 4'(hist[i]);
            check("row", 32'(kp.row), 32'(1) << m_row);
            check("key_code", 32'(kp.key_code), 32'(m_code));
            check("key_valid", 32'(kp.key_valid), 32'(reset && m_accepts()));
            check("pressed", 32'(kp.pressed), 32'(m_held));
            check("digits", 32'(kp.digits), 32'(d));
            if (kp.key_valid === 1'b1) kv_count++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_pressed(input logic lvl, input string name);
        int n = 0;
        while (kp.pressed !== lvl && n < 100) begin
            step(1);
            n++;
        end
        check(name, 32'(kp.pressed), 32'(lvl));
    endtask

    initial begin
        int n;
        for (int r = 0; r < ROWS; r++) keys[r] = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;

        // Reset values and row rotation every SCAN_DIV cycles
        check("rst_row", 32'(kp.row), 32'h1);
        check("rst_code", 32'(kp.key_code), 32'd13);
        check("rst_digits", 32'(kp.digits), 32'hDD);
        check("rst_valid", 32'(kp.key_valid), 32'h0);
        check("rst_pressed", 32'(kp.pressed), 32'h0);
        step(4);
        check("rot_row1", 32'(kp.row), 32'h2);
        step(4);
        check("rot_row2", 32'(kp.row), 32'h4);

        // Clean press of row2/col1 -> code 9
        keys[2][1] = 1'b1;
        wait_pressed(1'b1, "press9_wait");
        check("press9_code", 32'(kp.key_code), 32'd9);
        check("press9_digits", 32'(kp.digits), 32'hD9);
        check("press9_pulses", 32'(kv_count), 32'd1);
        step(8);
        check("held_row", 32'(kp.row), 32'h4);

        // Release chatter: drop for one tick, then restore
        keys[2][1] = 1'b0;
        n = 0;
        while (m_rel != 1 && n < 60) begin step(1); n++; end
        check("chatter_seen", 32'(n < 60), 32'h1);
        keys[2][1] = 1'b1;
        step(24);
        check("chatter_pressed", 32'(kp.pressed), 32'h1);
        check("chatter_pulses", 32'(kv_count), 32'd1);
        keys[2][1] = 1'b0;
        wait_pressed(1'b0, "release_wait");
        check("release_row", 32'(kp.row), 32'h8);
        check("release_pulses", 32'(kv_count), 32'd1);

        // Bounce: key present for two ticks only
        keys[2][1] = 1'b1;
        n = 0;
        while (!(m_lock >= 0 && m_agree == 2) && n < 80) begin step(1); n++; end
        check("bounce_seen", 32'(n < 80), 32'h1);
        keys[2][1] = 1'b0;
        n = 0;
        while (kp.row === 4'b0100 && n < 20) begin step(1); n++; end
        check("bounce_row", 32'(kp.row), 32'h8);
        check("bounce_pulses", 32'(kv_count), 32'd1);
        check("bounce_digits", 32'(kp.digits), 32'hD9);

        // Two presses: 9 then 3
        keys[2][1] = 1'b1;
        wait_pressed(1'b1, "second9_wait");
        keys[2][1] = 1'b0;
        wait_pressed(1'b0, "second9_release");
        keys[0][3] = 1'b1;
        wait_pressed(1'b1, "press3_wait");
        check("press3_code", 32'(kp.key_code), 32'd3);
        check("press3_digits", 32'(kp.digits), 32'h93);
        check("press3_pulses", 32'(kv_count), 32'd3);
        keys[0][3] = 1'b0;
        wait_pressed(1'b0, "press3_release");

        // Column priority: col3 and col0 together
        keys[0][3] = 1'b1;
        keys[0][0] = 1'b1;
        wait_pressed(1'b1, "prio_wait");
        check("prio_code", 32'(kp.key_code), 32'd3);
        check("prio_digits", 32'(kp.digits), 32'h33);
        check("prio_pulses", 32'(kv_count), 32'd4);

        // Reset while HELD, key still down afterwards
        reset = 1'b0;
        step(1);
        check("midrst_row", 32'(kp.row), 32'h1);
        check("midrst_code", 32'(kp.key_code), 32'd13);
        check("midrst_digits", 32'(kp.digits), 32'hDD);
        check("midrst_pressed", 32'(kp.pressed), 32'h0);
        check("midrst_valid", 32'(kp.key_valid), 32'h0);
        reset = 1'b1;
        wait_pressed(1'b1, "reaccept_wait");
        check("reaccept_code", 32'(kp.key_code), 32'd3);
        check("reaccept_digits", 32'(kp.digits), 32'hD3);
        check("reaccept_pulses", 32'(kv_count), 32'd5);
        step(40);
        check("reaccept_once", 32'(kv_count), 32'd5);
        keys[0][3] = 1'b0;
        keys[0][0] = 1'b0;
        step(30);
        check("final_pressed", 32'(kp.pressed), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
